// File: rtl/aib_io_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aib_io_cfg_ctrl
// Description : Per-IO static configuration controller for the AIB IO buffer
//               array. Serves single-IO or broadcast read/write requests over
//               a 4-phase req/ack port. Any write that touches an enabled
//               transmitter, or enables one, runs the sequence
//               tx-off -> settle -> apply -> settle -> tx-on, so a pad is
//               never driven while its mode or drive is changing.
// Ports       : i_clk, i_rst_n            clock, async active-low reset
//               i_cfg_req/wr/bcast/addr/wdata   request port (held until ack)
//               o_cfg_ack/err/rdata       one-cycle completion pulse + status
//               o_busy                    high from accept until ack
//               c_io_* / c_drv_*          per-IO configuration flops
// Revision    : 1.0 - initial release
// ============================================================================
module aib_io_cfg_ctrl #(
    parameter int NumIo        = 96,
    parameter int SettleCycles = 4,
    parameter int AddrW        = $clog2(NumIo)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cfg_req,
    input  logic                  i_cfg_wr,
    input  logic                  i_cfg_bcast,
    input  logic [AddrW-1:0]      i_cfg_addr,
    input  logic [8:0]            i_cfg_wdata,
    output logic                  o_cfg_ack,
    output logic                  o_cfg_err,
    output logic [8:0]            o_cfg_rdata,
    output logic                  o_busy,
    output logic [NumIo-1:0]      c_io_tx_en,
    output logic [NumIo-1:0]      c_io_ddr_mode,
    output logic [NumIo-1:0]      c_io_async_mode,
    output logic [NumIo-1:0][3:0] c_drv_strength,
    output logic [NumIo-1:0]      c_drv_pull_up,
    output logic [NumIo-1:0]      c_drv_pull_down
);

    localparam logic [7:0]     c_SETTLE_LOAD = 8'(SettleCycles - 1);
    localparam logic [AddrW:0] c_NUM_IO      = (AddrW + 1)'(NumIo);

    // TX_OFF is the decode cycle: its exit edge (edge 1) either completes the
    // request or turns the transmitter(s) off. The exit edge of WAIT1 applies
    // the non-tx fields and the exit edge of WAIT2 turns tx back on with ack.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TX_OFF = 2'd1;
    localparam logic [1:0] ST_WAIT1  = 2'd2;
    localparam logic [1:0] ST_WAIT2  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic                  wr_q, bcast_q;
    logic [AddrW-1:0]      addr_q;
    logic [8:0]            wdata_q;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [8:0]            rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic [NumIo-1:0]      tx_q, tx_d;
    logic [NumIo-1:0]      ddr_q, ddr_d;
    logic [NumIo-1:0]      async_q, async_d;
    logic [NumIo-1:0][3:0] str_q, str_d;
    logic [NumIo-1:0]      pu_q, pu_d;
    logic [NumIo-1:0]      pd_q, pd_d;

    logic [NumIo-1:0]      w_mask;
    logic [8:0]            w_rd;
    logic                  w_addr_bad;
    logic                  w_err;
    logic                  w_safe;
    logic                  w_accept;

    // Target mask and read-back mux; an out-of-range address yields an empty
    // mask, so no array is ever indexed past NumIo.
    always_comb begin
        w_mask = '0;
        w_rd   = '0;
        for (int i = 0; i < NumIo; i++) begin
            if (bcast_q || (addr_q == AddrW'(i))) begin
                w_mask[i] = 1'b1;
            end
            if (addr_q == AddrW'(i)) begin
                w_rd = {tx_q[i], ddr_q[i], async_q[i], str_q[i], pu_q[i], pd_q[i]};
            end
        end
    end

    assign w_addr_bad = ({1'b0, addr_q} >= c_NUM_IO);
    // Broadcast only exempts writes from the address check.
    assign w_err      = (w_addr_bad && !(wr_q && bcast_q)) ||
                        (wr_q && wdata_q[1] && wdata_q[0]);
    assign w_safe     = wr_q && !w_err && (wdata_q[8] || (|(tx_q & w_mask)));
    assign w_accept   = (state_q == ST_IDLE) && i_cfg_req && armed_q;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) state_d = ST_TX_OFF;
            end
            ST_TX_OFF: begin
                if (w_safe) begin
                    state_d = ST_WAIT1;
                    cnt_d   = c_SETTLE_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT1: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_WAIT2;
                    cnt_d   = c_SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_WAIT2: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        busy_d  = busy_q;
        tx_d    = tx_q;
        ddr_d   = ddr_q;
        async_d = async_q;
        str_d   = str_q;
        pu_d    = pu_q;
        pd_d    = pd_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) busy_d = 1'b1;
            end
            ST_TX_OFF: begin
                if (w_err) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end else if (!wr_q) begin
                    ack_d   = 1'b1;
                    rdata_d = w_rd;
                end else if (!w_safe) begin
                    ack_d = 1'b1;
                    for (int i = 0; i < NumIo; i++) begin
                        if (w_mask[i]) begin
                            {tx_d[i], ddr_d[i], async_d[i], str_d[i], pu_d[i], pd_d[i]} = wdata_q;
                        end
                    end
                end else begin
                    tx_d = tx_q & ~w_mask;
                end
            end
            ST_WAIT1: begin
                if (cnt_q == 8'd0) begin
                    for (int i = 0; i < NumIo; i++) begin
                        if (w_mask[i]) begin
                            {ddr_d[i], async_d[i], str_d[i], pu_d[i], pd_d[i]} = wdata_q[7:0];
                        end
                    end
                end
            end
            ST_WAIT2: begin
                if (cnt_q == 8'd0) begin
                    ack_d = 1'b1;
                    for (int i = 0; i < NumIo; i++) begin
                        if (w_mask[i]) tx_d[i] = wdata_q[8];
                    end
                end
            end
            default: ;
        endcase
        if (ack_d) busy_d = 1'b0;
        // 4-phase: re-arm only after req has been seen low.
        armed_d = ack_d ? 1'b0 : (armed_q | ~i_cfg_req);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_q <= 1'b1;
            wr_q    <= 1'b0;
            bcast_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            tx_q    <= '0;
            ddr_q   <= '0;
            async_q <= '0;
            str_q   <= '0;
            pu_q    <= '0;
            pd_q    <= '1;
        end else begin
            if (w_accept) begin
                wr_q    <= i_cfg_wr;
                bcast_q <= i_cfg_bcast;
                addr_q  <= i_cfg_addr;
                wdata_q <= i_cfg_wdata;
            end
            armed_q <= armed_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            ddr_q   <= ddr_d;
            async_q <= async_d;
            str_q   <= str_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
        end
    end

    assign o_cfg_ack       = ack_q;
    assign o_cfg_err       = err_q;
    assign o_cfg_rdata     = rdata_q;
    assign o_busy          = busy_q;
    assign c_io_tx_en      = tx_q;
    assign c_io_ddr_mode   = ddr_q;
    assign c_io_async_mode = async_q;
    assign c_drv_strength  = str_q;
    assign c_drv_pull_up   = pu_q;
    assign c_drv_pull_down = pd_q;

endmodule
`default_nettype wire

// File: tb/tb_aib_io_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aib_io_cfg_ctrl
// Description : Scoreboard bench for aib_io_cfg_ctrl. Stimulus pushes the
//               expected {err, rdata, latency} of each request; a monitor
//               pops and compares on every ack. Sequencing timing is checked
//               cycle by cycle against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aib_io_cfg_ctrl;

    localparam int N = 96;
    localparam int S = 4;

    typedef struct packed {
        logic       err;
        logic [8:0] rd;
        logic [7:0] lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0, wr = 1'b0, bcast = 1'b0;
    logic [6:0]       addr = '0;
    logic [8:0]       wdata = '0;
    logic             ack, err, busy;
    logic [8:0]       rdata;
    logic [N-1:0]     tx, ddr, asy, pu, pd;
    logic [N-1:0][3:0] str;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   start_cyc = 0;
    logic busy_prev = 1'b0;
    logic ack_prev  = 1'b0;
    exp_t sb_q[$];

    aib_io_cfg_ctrl #(.NumIo(N), .SettleCycles(S)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_req(req), .i_cfg_wr(wr), .i_cfg_bcast(bcast),
        .i_cfg_addr(addr), .i_cfg_wdata(wdata),
        .o_cfg_ack(ack), .o_cfg_err(err), .o_cfg_rdata(rdata), .o_busy(busy),
        .c_io_tx_en(tx), .c_io_ddr_mode(ddr), .c_io_async_mode(asy),
        .c_drv_strength(str), .c_drv_pull_up(pu), .c_drv_pull_down(pd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] io_cfg(input int i);
        return {tx[i], ddr[i], asy[i], str[i], pu[i], pd[i]};
    endfunction

    // Monitor: latency is measured from the busy rising edge (edge 0).
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_prev = 1'b0;
            ack_prev  = 1'b0;
        end else begin
            if (busy && !busy_prev) start_cyc = cyc;
            if (ack) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected ack", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack err", err, e.err);
                    chk("ack rdata", rdata, e.rd);
                    chk("ack latency", cyc - start_cyc, e.lat);
                end
            end else if (ack_prev) begin
                chk("post-ack rdata/err clear", {err, rdata}, 10'd0);
            end
            busy_prev = busy;
            ack_prev  = ack;
        end
    end

    task automatic wait_ack();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack) break;
        end
        if (k == 40) chk("ack timeout", 1'b0, 1'b1);
    endtask

    task automatic xact(input bit w, input bit b, input int a, input logic [8:0] wd,
                        input bit e_err, input logic [8:0] e_rd, input int e_lat);
        sb_q.push_back({e_err, e_rd, 8'(e_lat)});
        @(negedge clk);
        req = 1'b1; wr = w; bcast = b; addr = 7'(a); wdata = wd;
        wait_ack();
        req = 1'b0;
        @(negedge clk);
    endtask

    // Single-IO safe write, checking the target every cycle from edge 0.
    task automatic xact_safe(input int a, input logic [8:0] old_v, input logic [8:0] new_v);
        logic [8:0] cur;
        logic       e_tx;
        logic [7:0] e_rest;
        sb_q.push_back({1'b0, 9'd0, 8'(2 * S + 1)});
        @(negedge clk);
        req = 1'b1; wr = 1'b1; bcast = 1'b0; addr = 7'(a); wdata = new_v;
        for (int k = 0; k <= 2 * S + 1; k++) begin
            @(negedge clk);
            cur    = io_cfg(a);
            e_tx   = (k >= 2 * S + 1) ? new_v[8] : ((k >= 1) ? 1'b0 : old_v[8]);
            e_rest = (k >= S + 1) ? new_v[7:0] : old_v[7:0];
            chk($sformatf("safe io%0d tx_en k=%0d", a, k), cur[8], e_tx);
            chk($sformatf("safe io%0d fields k=%0d", a, k), cur[7:0], e_rest);
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ack/err/busy/rdata", {ack, err, busy, rdata}, 12'd0);
        chk("reset tx_en", tx, {N{1'b0}});
        chk("reset ddr/async", {ddr, asy}, {2 * N{1'b0}});
        chk("reset strength", str, {4 * N{1'b0}});
        chk("reset pull_up", pu, {N{1'b0}});
        chk("reset pull_down", pd, {N{1'b1}});
        rst_n = 1'b1;
        @(negedge clk);

        // Read back every IO
        for (int i = 0; i < N; i++) xact(1'b0, 1'b0, i, 9'd0, 1'b0, 9'b0_0_0_0000_0_1, 1);

        // Fast write IO5
        xact(1'b1, 1'b0, 5, 9'b0_1_0_0011_1_0, 1'b0, 9'd0, 1);
        chk("fast io5", io_cfg(5), 9'b0_1_0_0011_1_0);
        chk("fast io4 untouched", io_cfg(4), 9'b0_0_0_0000_0_1);
        chk("fast io6 untouched", io_cfg(6), 9'b0_0_0_0000_0_1);
        xact(1'b0, 1'b0, 5, 9'd0, 1'b0, 9'b0_1_0_0011_1_0, 1);

        // Safe write IO7: enable tx with full strength, then restrength while on
        xact_safe(7, 9'b0_0_0_0000_0_1, 9'b1_0_0_1111_0_1);
        chk("safe io6 untouched", io_cfg(6), 9'b0_0_0_0000_0_1);
        chk("safe io8 untouched", io_cfg(8), 9'b0_0_0_0000_0_1);
        xact_safe(7, 9'b1_0_0_1111_0_1, 9'b1_0_0_0011_0_1);
        xact(1'b0, 1'b0, 7, 9'd0, 1'b0, 9'b1_0_0_0011_0_1, 1);

        // Errors
        xact(1'b1, 1'b0, 96, 9'b0_0_0_0001_0_1, 1'b1, 9'd0, 1);
        xact(1'b0, 1'b0, 100, 9'd0, 1'b1, 9'd0, 1);
        xact(1'b1, 1'b0, 5, 9'b0_0_0_0000_1_1, 1'b1, 9'd0, 1);
        chk("err io5 unchanged", io_cfg(5), 9'b0_1_0_0011_1_0);
        chk("err io7 unchanged", io_cfg(7), 9'b1_0_0_0011_0_1);

        // Req held high after ack is not re-accepted
        sb_q.push_back({1'b0, 9'b0_1_0_0011_1_0, 8'd1});
        @(negedge clk);
        req = 1'b1; wr = 1'b0; bcast = 1'b0; addr = 7'd5;
        wait_ack();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("held req no accept k=%0d", k), {busy, ack}, 2'b00);
        end
        req = 1'b0;
        @(negedge clk);
        sb_q.push_back({1'b0, 9'b1_0_0_0011_0_1, 8'd1});
        req = 1'b1; addr = 7'd7;
        wait_ack();
        req = 1'b0;
        @(negedge clk);

        // Broadcast safe write, async reset at edge 6
        @(negedge clk);
        req = 1'b1; wr = 1'b1; bcast = 1'b1; addr = 7'd0; wdata = 9'b1_0_1_0101_1_0;
        for (int k = 0; k <= 5; k++) @(negedge clk);
        chk("bcast tx off at edge 5", tx, {N{1'b0}});
        chk("bcast strength at edge 5", str, {N{4'h5}});
        chk("bcast async at edge 5", asy, {N{1'b1}});
        chk("bcast busy", busy, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst busy/ack", {busy, ack, err, rdata}, 12'd0);
        chk("async rst tx_en", tx, {N{1'b0}});
        chk("async rst strength", str, {4 * N{1'b0}});
        chk("async rst pulls", {pu, pd}, {{N{1'b0}}, {N{1'b1}}});
        req = 1'b0; bcast = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 1'b0, 7, 9'd0, 1'b0, 9'b0_0_0_0000_0_1, 1);
        xact(1'b0, 1'b0, 5, 9'd0, 1'b0, 9'b0_0_0_0000_0_1, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
